multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
Sequential front/back-end for the team's 16-bit slice adder. It accepts a wide add or subtract request over a valid/ready handshake and feeds one 16-bit slice per cycle into the slice adder, LSB slice first. It chains the slice carry through a register and assembles the wide sum, carry-out and signed overflow. It returns the result over a valid/ready handshake, trading latency for a single 16-bit adder instance.

Parameters:
NUM_SLICES, 4, number of 16-bit slices; operand width W = 16*NUM_SLICES; legal range 2..8

Ports:
clk_i        input   1   single clock, all state on rising edge
rst_i        input   1   synchronous, active-high reset
in_valid_i   input   1   request valid
in_ready_o   output  1   block can accept a request (high only in IDLE)
a_i          input   W   operand A
b_i          input   W   operand B
cin_i        input   1   carry-in; ignored when sub_i=1
sub_i        input   1   1: compute A - B (B inverted, carry-in forced to 1)
out_valid_o  output  1   result valid
out_ready_i  input   1   consumer accepts result
sum_o        output  W   result
cout_o       output  1   carry out of MSB slice
ovf_o        output  1   two's-complement overflow
busy_o       output  1   high in RUN or DONE

Behaviour:
- Reset values (rst_i high at a clock edge, which dominates all other inputs): state=IDLE, out_valid_o=0, sum_o=0, cout_o=0, ovf_o=0, busy_o=0, slice index=0, carry reg=0. in_ready_o=1 from the first cycle after reset.
- FSM states:
  - IDLE:
    - in_ready_o=1.
    - On in_valid_i & in_ready_o: latch a_reg=a_i, b_reg=(sub_i ? ~b_i : b_i), carry_reg=(sub_i ? 1 : cin_i), idx=0, clear sum register, go to RUN.
  - RUN:
    - Each cycle, drive slice idx of a_reg/b_reg and carry_reg into the slice adder.
    - At the edge: write the slice sum into sum[16*idx +: 16], carry_reg <= slice Cout, idx <= idx+1.
    - At the edge where idx==NUM_SLICES-1: also register cout_o=slice Cout and ovf_o=(a_msb == b_eff_msb) & (sum_msb != a_msb); go to DONE.
    - in_ready_o=0 and in_valid_i is ignored.
  - DONE:
    - out_valid_o=1; sum_o/cout_o/ovf_o are held stable.
    - On out_ready_i=1: out_valid_o=0 at the next edge, go to IDLE.
    - out_ready_i=0 holds the state indefinitely; outputs must not change.
- Latency: for a request accepted at edge t, out_valid_o is high after edge t+NUM_SLICES.
- Throughput: with out_ready_i tied high, the minimum spacing between accepts is NUM_SLICES+2 cycles. There is no overlap of operations.
- Output register behaviour: sum_o, cout_o and ovf_o are registered. They update only on RUN edges and keep the last value in IDLE. The sum register is cleared on accept, so partial sums are visible while busy; consumers must qualify with out_valid_o.
- Carry chain: only the registered carry crosses slice boundaries. The slice adder stays purely combinational.
- Subtraction: cout_o=1 means no borrow (A >= B unsigned).
- Handshake rules: out_valid_o never drops without out_ready_i. No combinational path from out_ready_i to in_ready_o.
- Reset mid-operation (RUN or DONE): next cycle IDLE with all outputs at reset values. The in-flight request is dropped with no output.
- Simultaneous events: rst_i together with in_valid_i means the request is not accepted.

Decomposition:
- Package add_seq_pkg holds:
  - localparam SLICE_W=16
  - enum state_t {IDLE, RUN, DONE} (2-bit)
  - function slice_idx_w(NUM_SLICES) giving the index width $clog2
- Sub-module: one instance of the existing 16-bit adder carry_lookahead_adder (A_i, B_i, Cin, Sum_o, Cout). No other sub-modules.

Test Plan (NUM_SLICES=4, W=64):
1. Cross-slice carry: a=0x0000_0000_0000_FFFF, b=0x1, cin=0, sub=0 -> sum_o=0x0000_0000_0001_0000, cout_o=0, ovf_o=0; out_valid_o high 4 cycles after the accept edge.
2. Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum_o=0, cout_o=1, ovf_o=0.
3. Subtract with borrow: a=5, b=7, sub=1, cin=1 (ignored) -> sum_o=0xFFFF_FFFF_FFFF_FFFE, cout_o=0, ovf_o=0. Then a=7, b=5, sub=1 -> sum_o=2, cout_o=1.
4. Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum_o=0x8000_0000_0000_0000, ovf_o=1, cout_o=0. Then a=b=0x8000_0000_0000_0000 -> sum_o=0, cout_o=1, ovf_o=1.
5. Backpressure: out_ready_i=0 for 10 cycles in DONE while a new in_valid_i is offered -> outputs stable, in_ready_o=0, no accept. Raise out_ready_i -> handshake; the new request is accepted 2 edges later and its result is correct.
6. Reset mid-RUN: assert rst_i one cycle after 2 slices complete -> next cycle state IDLE, out_valid_o=0, sum_o=0, in_ready_o=1, no stray out_valid_o. A subsequent request (scenario 1 values) gives the correct result.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the slice-serial wide adder.
package add_seq_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned slice_idx_w(input int unsigned num_slices);
        return $clog2(num_slices);
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups plus a group-level lookahead unit.
module carry_lookahead_adder (
    input  logic [15:0] A_i,
    input  logic [15:0] B_i,
    input  logic        Cin,
    output logic [15:0] Sum_o,
    output logic        Cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = A_i & B_i;
    assign p = A_i ^ B_i;

    genvar k;
    generate
        for (k = 0; k < 4; k = k + 1) begin : g_grp
            assign gg[k] = g[4*k+3]
                         | (p[4*k+3] & g[4*k+2])
                         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            assign gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];

            assign c[4*k]   = gc[k];
            assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            assign c[4*k+2] = g[4*k+1]
                            | (p[4*k+1] & g[4*k])
                            | (p[4*k+1] & p[4*k] & gc[k]);
            assign c[4*k+3] = g[4*k+2]
                            | (p[4*k+2] & g[4*k+1])
                            | (p[4*k+2] & p[4*k+1] & g[4*k])
                            | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
    endgenerate

    // Group carries are flattened so none of them waits on another group carry.
    assign gc[0] = Cin;
    assign gc[1] = gg[0] | (gp[0] & Cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & Cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);

    assign Sum_o = p ^ c;
    assign Cout  = gc[4];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract built from one 16-bit slice adder, one slice per cycle LSB first,
// with the inter-slice carry held in a register. Valid/ready on both request and result.
module multiword_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int unsigned NUM_SLICES = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [SLICE_W*NUM_SLICES-1:0]   a_i,
    input  logic [SLICE_W*NUM_SLICES-1:0]   b_i,
    input  logic                            cin_i,
    input  logic                            sub_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [SLICE_W*NUM_SLICES-1:0]   sum_o,
    output logic                            cout_o,
    output logic                            ovf_o,
    output logic                            busy_o
);

    localparam int unsigned W  = SLICE_W * NUM_SLICES;
    localparam int unsigned IW = slice_idx_w(NUM_SLICES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLICES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      sum_q;
    logic [IW-1:0]     idx_q;
    logic              carry_q;
    logic              cout_q;
    logic              ovf_q;

    logic              accept;
    logic              last_slice;
    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] slice_sum;
    logic              slice_cout;

    assign a_slice    = a_q[idx_q*SLICE_W +: SLICE_W];
    assign b_slice    = b_q[idx_q*SLICE_W +: SLICE_W];
    assign last_slice = (idx_q == LAST_IDX);

    carry_lookahead_adder u_slice_add (
        .A_i   (a_slice),
        .B_i   (b_slice),
        .Cin   (carry_q),
        .Sum_o (slice_sum),
        .Cout  (slice_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Subtraction is folded in at accept time: B is stored inverted with carry-in forced high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i ? 1'b1 : cin_i;
            idx_q   <= '0;
            sum_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
            carry_q <= slice_cout;
            idx_q   <= idx_q + 1'b1;
            if (last_slice) begin
                cout_q <= slice_cout;
                ovf_q  <= (a_q[W-1] == b_q[W-1]) & (slice_sum[SLICE_W-1] != a_q[W-1]);
            end
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed self-checking bench for multiword_add_sequencer with NUM_SLICES=4 (64-bit operands).
module tb_multiword_add_sequencer;

    localparam int unsigned NS = 4;
    localparam int unsigned W  = 64;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cin_i = 1'b0;
    logic         sub_i = 1'b0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;
    logic         busy_o;

    int n_cmp = 0;
    int n_err = 0;

    multiword_add_sequencer #(.NUM_SLICES(NS)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .sub_i       (sub_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one request and returns just after its accept edge.
    task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        a_i = a; b_i = b; cin_i = cin; sub_i = sub;
        in_valid_i = 1'b1;
        check({tag, ".in_ready"}, W'(in_ready_o), W'(1));
        tick();
        in_valid_i = 1'b0;
        check({tag, ".busy"}, W'(busy_o), W'(1));
        check({tag, ".sumclr"}, sum_o, '0);
    endtask

    // Waits (bounded) for the result, checks latency and values, optionally completes the handshake.
    task automatic collect(input string tag, input logic [W-1:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf, input logic release_out);
        int cnt = 0;
        while (!out_valid_o && cnt < 20) begin
            tick();
            cnt++;
        end
        check({tag, ".latency"}, W'(cnt), W'(NS));
        check({tag, ".sum"}, sum_o, exp_sum);
        check({tag, ".cout"}, W'(cout_o), W'(exp_cout));
        check({tag, ".ovf"}, W'(ovf_o), W'(exp_ovf));
        if (release_out) begin
            out_ready_i = 1'b1;
            tick();
            out_ready_i = 1'b0;
            check({tag, ".vdrop"}, W'(out_valid_o), W'(0));
            check({tag, ".idle_rdy"}, W'(in_ready_o), W'(1));
            check({tag, ".hold"}, sum_o, exp_sum);
        end
    endtask

    initial begin
        tick();
        tick();
        rst_i = 1'b0;
        check("rst.valid", W'(out_valid_o), W'(0));
        check("rst.sum", sum_o, '0);
        check("rst.cout", W'(cout_o), W'(0));
        check("rst.ovf", W'(ovf_o), W'(0));
        check("rst.busy", W'(busy_o), W'(0));
        check("rst.ready", W'(in_ready_o), W'(1));

        send("carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        collect("carry", 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b1);

        send("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        collect("ripple", 64'h0, 1'b1, 1'b0, 1'b1);

        send("sub57", 64'd5, 64'd7, 1'b1, 1'b1);
        collect("sub57", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);

        send("sub75", 64'd7, 64'd5, 1'b0, 1'b1);
        collect("sub75", 64'd2, 1'b1, 1'b0, 1'b1);

        send("ovfpos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        collect("ovfpos", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);

        send("ovfneg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        collect("ovfneg", 64'h0, 1'b1, 1'b1, 1'b1);

        // Backpressure with a competing request offered while the result is held.
        send("bp", 64'h0000_1234_0000_0010, 64'h0000_0001_0000_0020, 1'b0, 1'b0);
        collect("bp", 64'h0000_1235_0000_0030, 1'b0, 1'b0, 1'b0);
        a_i = 64'd100; b_i = 64'd200; cin_i = 1'b1; sub_i = 1'b0;
        in_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp.valid", W'(out_valid_o), W'(1));
            check("bp.stable", sum_o, 64'h0000_1235_0000_0030);
            check("bp.noready", W'(in_ready_o), W'(0));
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("bp.vdrop", W'(out_valid_o), W'(0));
        check("bp.rdy", W'(in_ready_o), W'(1));
        tick();
        in_valid_i = 1'b0;
        check("bp.accept", W'(busy_o), W'(1));
        check("bp.sumclr", sum_o, '0);
        collect("bp2", 64'd301, 1'b0, 1'b0, 1'b1);

        // Reset after two slices have completed.
        send("mid", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid.valid", W'(out_valid_o), W'(0));
        check("mid.sum", sum_o, '0);
        check("mid.ready", W'(in_ready_o), W'(1));
        check("mid.busy", W'(busy_o), W'(0));
        check("mid.cout", W'(cout_o), W'(0));
        for (int i = 0; i < 6; i++) tick();
        check("mid.nostray", W'(out_valid_o), W'(0));
        send("post", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        collect("post", 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
